// File: rtl/wbupsz_wc_if.sv
// rtl/wbupsz_wc_if.sv - narrow-request and wide-memory Wishbone signal bundle for wbupsz_wc
interface wbupsz_wc_if #(
    parameter int ADDRESS_WIDTH = 28,
    parameter int WIDE_DW       = 512,
    parameter int SMALL_DW      = 32
) ();
    localparam int SAW = ADDRESS_WIDTH - $clog2(SMALL_DW / 8);
    localparam int WAW = ADDRESS_WIDTH - $clog2(WIDE_DW / 8);

    logic                  i_scyc, i_sstb, i_swe;
    logic [SAW-1:0]        i_saddr;
    logic [SMALL_DW-1:0]   i_sdata;
    logic [SMALL_DW/8-1:0] i_ssel;
    logic                  o_sstall, o_sack, o_serr;
    logic [SMALL_DW-1:0]   o_sdata;

    logic                  o_wcyc, o_wstb, o_wwe;
    logic [WAW-1:0]        o_waddr;
    logic [WIDE_DW-1:0]    o_wdata;
    logic [WIDE_DW/8-1:0]  o_wsel;
    logic                  i_wstall, i_wack, i_werr;
    logic [WIDE_DW-1:0]    i_wdata;

    modport slave (
        input  i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        output o_sstall, o_sack, o_serr, o_sdata,
        output o_wcyc, o_wstb, o_wwe, o_waddr, o_wdata, o_wsel,
        input  i_wstall, i_wack, i_werr, i_wdata
    );

    modport master (
        output i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        input  o_sstall, o_sack, o_serr, o_sdata,
        input  o_wcyc, o_wstb, o_wwe, o_waddr, o_wdata, o_wsel,
        output i_wstall, i_wack, i_werr, i_wdata
    );
endinterface

// File: rtl/wbupsz_wc_sfifo.sv
// rtl/wbupsz_wc_sfifo.sv - synchronous first-word-fall-through FIFO
module sfifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [BW-1:0] i_data,
    output logic          o_full,
    input  logic          i_rd,
    output logic [BW-1:0] o_data,
    output logic          o_empty
);
    logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0] wr_ptr, rd_ptr;
    logic            do_wr, do_rd;

    assign do_wr   = i_wr && !o_full;
    assign do_rd   = i_rd && !o_empty;
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN])
                  && (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);
    assign o_data  = mem[rd_ptr[LGFLEN-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + (LGFLEN+1)'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + (LGFLEN+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr)
            mem[wr_ptr[LGFLEN-1:0]] <= i_data;
    end
endmodule

// File: rtl/wbupsz_wc.sv
// rtl/wbupsz_wc.sv - pipelined Wishbone upsizer with write coalescing while the wide bus stalls
module wbupsz_wc #(
    parameter int ADDRESS_WIDTH     = 28,
    parameter int WIDE_DW           = 512,
    parameter int SMALL_DW          = 32,
    parameter int LGFIFO            = 5,
    parameter bit OPT_LITTLE_ENDIAN = 1'b0,
    parameter bit OPT_COALESCE      = 1'b1,
    parameter bit OPT_LOWPOWER      = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    wbupsz_wc_if.slave bus
);
    localparam int RATIO = WIDE_DW / SMALL_DW;
    localparam int LGR   = $clog2(RATIO);
    localparam int SSW   = SMALL_DW / 8;
    localparam int WSW   = WIDE_DW / 8;
    localparam int SAW   = ADDRESS_WIDTH - $clog2(SSW);
    localparam int WAW   = SAW - LGR;
    localparam int DSW   = $clog2(WIDE_DW);
    localparam int SSHW  = $clog2(WSW);
    localparam int ACKW  = $clog2(RATIO * (2**LGFIFO)) + 1;

    // Lane 0 sits in the MSBs unless little endian.
    function automatic logic [LGR-1:0] lane_pos(input logic [LGR-1:0] l);
        return OPT_LITTLE_ENDIAN ? l : ~l;
    endfunction

    logic                 r_stb, r_we, r_wcyc, r_serr, r_err_hold, r_rack;
    logic [WAW-1:0]       r_addr;
    logic [WIDE_DW-1:0]   r_data;
    logic [WSW-1:0]       r_sel;
    logic [LGR-1:0]       r_first, r_last;
    logic [LGR:0]         r_count;
    logic [ACKW-1:0]      ack_cnt, ack_add, ack_dec;
    logic [SMALL_DW-1:0]  r_sdata;

    logic [LGR-1:0]       lane, head_first, head_cm1;
    logic [WAW-1:0]       in_addr;
    logic [WIDE_DW-1:0]   wide_sdata, rdata_sh;
    logic [WSW-1:0]       wide_ssel;
    logic [2*LGR-1:0]     fifo_wdata, fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                 err_ev, flush, busy, merge_ok, stall_raw, req, load, merge, wstb;

    assign lane       = bus.i_saddr[LGR-1:0];
    assign in_addr    = bus.i_saddr[SAW-1:LGR];
    assign wide_sdata = WIDE_DW'(bus.i_sdata) << (DSW'(lane_pos(lane)) * DSW'(SMALL_DW));
    assign wide_ssel  = WSW'(bus.i_ssel) << (SSHW'(lane_pos(lane)) * SSHW'(SSW));
    assign head_first = fifo_rdata[2*LGR-1:LGR];
    assign head_cm1   = fifo_rdata[LGR-1:0];
    assign rdata_sh   = bus.i_wdata >> (DSW'(lane_pos(head_first)) * DSW'(SMALL_DW));

    assign err_ev = bus.i_werr && r_wcyc;
    assign flush  = i_reset || !bus.i_scyc || err_ev;
    assign busy   = r_stb || !fifo_empty || (ack_cnt != '0);

    // Merge only strictly ascending, contiguous lanes of the same wide word.
    assign merge_ok = OPT_COALESCE && r_stb && (bus.i_wstall || fifo_full)
                   && bus.i_swe && r_we && (in_addr == r_addr)
                   && ((LGR+1)'(lane) == (LGR+1)'(r_last) + (LGR+1)'(1))
                   && (r_count < (LGR+1)'(RATIO));

    assign stall_raw = (r_stb && (bus.i_wstall || fifo_full) && !merge_ok)
                    || (busy && (bus.i_swe != r_we))
                    || r_err_hold || r_serr;
    assign req   = bus.i_scyc && bus.i_sstb && !stall_raw;
    assign merge = req && merge_ok;
    assign load  = req && !merge_ok;

    assign wstb       = r_stb && !fifo_full;
    assign fifo_push  = wstb && !bus.i_wstall;
    assign fifo_pop   = bus.i_wack && !fifo_empty;
    assign fifo_wdata = {r_first, r_last - r_first};

    sfifo #(.BW(2*LGR), .LGFLEN(LGFIFO)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (flush),
        .i_wr    (fifo_push),
        .i_data  (fifo_wdata),
        .o_full  (fifo_full),
        .i_rd    (fifo_pop),
        .o_data  (fifo_rdata),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (flush) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_stb   <= 1'b1;
            r_we    <= bus.i_swe;
            r_addr  <= in_addr;
            r_data  <= (OPT_LOWPOWER && !bus.i_swe) ? '0 : wide_sdata;
            r_sel   <= wide_ssel;
            r_first <= lane;
            r_last  <= lane;
            r_count <= (LGR+1)'(1);
        end else if (merge) begin
            r_data  <= r_data | wide_sdata;
            r_sel   <= r_sel | wide_ssel;
            r_last  <= lane;
            r_count <= r_count + (LGR+1)'(1);
        end else if (fifo_push) begin
            r_stb <= 1'b0;
            if (OPT_LOWPOWER) begin
                r_data <= '0;
                r_sel  <= '0;
            end
        end
    end

    always_comb begin
        ack_add = '0;
        if (fifo_pop && r_we)
            ack_add = ACKW'(head_cm1) + ACKW'(1);
        ack_dec = (ack_cnt != '0) ? ACKW'(1) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            ack_cnt <= '0;
            r_rack  <= 1'b0;
        end else begin
            ack_cnt <= ack_cnt + ack_add - ack_dec;
            r_rack  <= fifo_pop && !r_we;
        end

        if (i_reset && OPT_LOWPOWER)
            r_sdata <= '0;
        else if (fifo_pop && !r_we)
            r_sdata <= rdata_sh[SMALL_DW-1:0];
        else if (OPT_LOWPOWER)
            r_sdata <= '0;

        if (flush || r_serr)
            r_wcyc <= 1'b0;
        else if (load)
            r_wcyc <= 1'b1;

        r_serr <= !i_reset && bus.i_scyc && err_ev;

        // After a bus error every request waits for the master to end its cycle.
        if (i_reset || !bus.i_scyc)
            r_err_hold <= 1'b0;
        else if (err_ev)
            r_err_hold <= 1'b1;
    end

    assign bus.o_sstall = bus.i_scyc && stall_raw;
    assign bus.o_sack   = r_rack || (ack_cnt != '0);
    assign bus.o_serr   = r_serr;
    assign bus.o_sdata  = r_sdata;
    assign bus.o_wcyc   = r_wcyc;
    assign bus.o_wstb   = wstb;
    assign bus.o_wwe    = r_we;
    assign bus.o_waddr  = r_addr;
    assign bus.o_wdata  = r_data;
    assign bus.o_wsel   = r_sel;
endmodule

// File: tb/tb_wbupsz_wc.sv
// tb/tb_wbupsz_wc.sv - directed self-checking bench for wbupsz_wc (128/32 big endian, and 128/32 little endian with a 4-deep FIFO)
module tb_wbupsz_wc;
    localparam int AW  = 28;
    localparam int WDW = 128;
    localparam int SDW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wbupsz_wc_if #(.ADDRESS_WIDTH(AW), .WIDE_DW(WDW), .SMALL_DW(SDW)) ia ();
    wbupsz_wc_if #(.ADDRESS_WIDTH(AW), .WIDE_DW(WDW), .SMALL_DW(SDW)) ib ();

    wbupsz_wc #(
        .ADDRESS_WIDTH(AW), .WIDE_DW(WDW), .SMALL_DW(SDW), .LGFIFO(5),
        .OPT_LITTLE_ENDIAN(1'b0), .OPT_COALESCE(1'b1), .OPT_LOWPOWER(1'b0)
    ) dut_a (.i_clk(clk), .i_reset(rst), .bus(ia.slave));

    wbupsz_wc #(
        .ADDRESS_WIDTH(AW), .WIDE_DW(WDW), .SMALL_DW(SDW), .LGFIFO(2),
        .OPT_LITTLE_ENDIAN(1'b1), .OPT_COALESCE(1'b1), .OPT_LOWPOWER(1'b0)
    ) dut_b (.i_clk(clk), .i_reset(rst), .bus(ib.slave));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        ia.i_scyc = 0; ia.i_sstb = 0; ia.i_swe = 0; ia.i_saddr = '0; ia.i_sdata = '0; ia.i_ssel = '0;
        ia.i_wstall = 0; ia.i_wack = 0; ia.i_werr = 0; ia.i_wdata = '0;
        ib.i_scyc = 0; ib.i_sstb = 0; ib.i_swe = 0; ib.i_saddr = '0; ib.i_sdata = '0; ib.i_ssel = '0;
        ib.i_wstall = 0; ib.i_wack = 0; ib.i_werr = 0; ib.i_wdata = '0;

        repeat (2) tick();
        rst = 0;
        tick();
        chk("rst_wcyc", ia.o_wcyc, 0);
        chk("rst_wstb", ia.o_wstb, 0);
        chk("rst_sack", ia.o_sack, 0);
        chk("rst_serr", ia.o_serr, 0);
        chk("rst_sstall", ia.o_sstall, 0);

        // 1: single read of lane 1 in wide word 1
        ia.i_scyc = 1; ia.i_sstb = 1; ia.i_swe = 0; ia.i_saddr = 26'h5; ia.i_ssel = 4'hF;
        #1 chk("rd_stall", ia.o_sstall, 0);
        tick(); ia.i_sstb = 0;
        chk("rd_wcyc", ia.o_wcyc, 1);
        chk("rd_wstb", ia.o_wstb, 1);
        chk("rd_wwe", ia.o_wwe, 0);
        chk("rd_waddr", ia.o_waddr, 24'h1);
        chk("rd_wsel", ia.o_wsel, 16'h0F00);
        tick();
        chk("rd_wstb_done", ia.o_wstb, 0);
        ia.i_wack = 1; ia.i_wdata = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        #1 chk("rd_sack_early", ia.o_sack, 0);
        tick(); ia.i_wack = 0;
        chk("rd_sack", ia.o_sack, 1);
        chk("rd_sdata", ia.o_sdata, 32'h44556677);
        tick();
        chk("rd_sack_once", ia.o_sack, 0);

        // 2: four stalled writes into one wide word merge into a single write
        ia.i_wstall = 1; ia.i_swe = 1; ia.i_sstb = 1; ia.i_ssel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            ia.i_saddr = 26'h8 + 26'(k); ia.i_sdata = 32'(k + 1);
            #1 chk($sformatf("co_stall%0d", k), ia.o_sstall, 0);
            tick();
        end
        ia.i_sstb = 0;
        chk("co_wstb", ia.o_wstb, 1);
        chk("co_wwe", ia.o_wwe, 1);
        chk("co_waddr", ia.o_waddr, 24'h2);
        chk("co_wsel", ia.o_wsel, 16'hFFFF);
        chk("co_wdata", ia.o_wdata, 128'h00000001_00000002_00000003_00000004);
        ia.i_wstall = 0;
        tick();
        chk("co_single_wstb", ia.o_wstb, 0);
        ia.i_wack = 1;
        tick(); ia.i_wack = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) chk($sformatf("co_sack%0d", k), ia.o_sack, 1);
            n += int'(ia.o_sack);
            tick();
        end
        chk("co_sack_total", 128'(n), 128'd4);

        // 3: a lane gap is not merged
        ia.i_wstall = 1; ia.i_sstb = 1; ia.i_saddr = 26'h8; ia.i_sdata = 32'h5;
        #1 chk("gap_stall0", ia.o_sstall, 0);
        tick();
        ia.i_saddr = 26'hA; ia.i_sdata = 32'h6;
        #1 chk("gap_stall1", ia.o_sstall, 1);
        chk("gap_wsel0", ia.o_wsel, 16'hF000);
        chk("gap_wdata0", ia.o_wdata, 128'h00000005_00000000_00000000_00000000);
        ia.i_wstall = 0;
        #1 chk("gap_stall_rel", ia.o_sstall, 0);
        tick(); ia.i_sstb = 0;
        chk("gap_wstb1", ia.o_wstb, 1);
        chk("gap_wsel1", ia.o_wsel, 16'h00F0);
        chk("gap_wdata1", ia.o_wdata, 128'h00000000_00000000_00000006_00000000);
        tick();
        ia.i_wack = 1;
        n = 0;
        tick(); n += int'(ia.o_sack);
        tick(); n += int'(ia.o_sack); ia.i_wack = 0;
        repeat (3) begin tick(); n += int'(ia.o_sack); end
        chk("gap_sack_total", 128'(n), 128'd2);

        // 4: read after write waits for the write to drain
        ia.i_sstb = 1; ia.i_swe = 1; ia.i_saddr = 26'h8; ia.i_sdata = 32'h7;
        #1 chk("dir_stall_w", ia.o_sstall, 0);
        tick();
        ia.i_swe = 0; ia.i_saddr = 26'h9;
        #1 chk("dir_stall_rstb", ia.o_sstall, 1);
        tick();
        chk("dir_stall_fifo", ia.o_sstall, 1);
        ia.i_wack = 1;
        tick(); ia.i_wack = 0;
        #1 chk("dir_wr_sack", ia.o_sack, 1);
        chk("dir_stall_ack", ia.o_sstall, 1);
        tick();
        chk("dir_sack_done", ia.o_sack, 0);
        chk("dir_stall_free", ia.o_sstall, 0);
        tick(); ia.i_sstb = 0;
        chk("dir_rd_wstb", ia.o_wstb, 1);
        chk("dir_rd_wwe", ia.o_wwe, 0);
        chk("dir_rd_waddr", ia.o_waddr, 24'h2);
        chk("dir_rd_wsel", ia.o_wsel, 16'h0F00);
        tick();
        ia.i_wack = 1; ia.i_wdata = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
        tick(); ia.i_wack = 0;
        chk("dir_rd_sack", ia.o_sack, 1);
        chk("dir_rd_sdata", ia.o_sdata, 32'hB1B1B1B1);
        tick();

        // 5: bus error with two reads outstanding
        ia.i_sstb = 1; ia.i_swe = 0; ia.i_saddr = 26'h0;
        #1 chk("err_stall0", ia.o_sstall, 0);
        tick();
        ia.i_saddr = 26'h4;
        #1 chk("err_stall1", ia.o_sstall, 0);
        tick(); ia.i_sstb = 0;
        tick();
        ia.i_werr = 1;
        tick(); ia.i_werr = 0;
        chk("err_serr", ia.o_serr, 1);
        chk("err_wcyc", ia.o_wcyc, 0);
        chk("err_sack", ia.o_sack, 0);
        ia.i_sstb = 1; ia.i_saddr = 26'h0;
        #1 chk("err_stall_serr", ia.o_sstall, 1);
        tick();
        chk("err_serr_once", ia.o_serr, 0);
        chk("err_sack_after", ia.o_sack, 0);
        chk("err_stall_hold", ia.o_sstall, 1);
        chk("err_wcyc_low", ia.o_wcyc, 0);
        ia.i_scyc = 0; ia.i_sstb = 0;
        #1 chk("err_stall_nocyc", ia.o_sstall, 0);
        tick();
        chk("err_idle_wstb", ia.o_wstb, 0);

        // 6: 4-deep FIFO fills, then reset and a fresh little-endian read
        ib.i_scyc = 1; ib.i_sstb = 1; ib.i_swe = 0; ib.i_ssel = 4'hF;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            ib.i_saddr = 26'(k);
            #1 chk($sformatf("ff_stall%0d", k), ib.o_sstall, 0);
            tick();
            n += int'(ib.o_wstb && !ib.i_wstall);
        end
        ib.i_saddr = 26'h5;
        #1 chk("ff_stall_full", ib.o_sstall, 1);
        chk("ff_issued", 128'(n), 128'd4);
        chk("ff_wstb_full", ib.o_wstb, 0);
        ib.i_sstb = 0;
        rst = 1;
        tick(); rst = 0;
        chk("ff_rst_wcyc", ib.o_wcyc, 0);
        chk("ff_rst_wstb", ib.o_wstb, 0);
        chk("ff_rst_sack", ib.o_sack, 0);
        chk("ff_rst_serr", ib.o_serr, 0);
        chk("ff_rst_sstall", ib.o_sstall, 0);
        chk("ff_rst_waddr", ib.o_waddr, 24'h0);
        ib.i_sstb = 1; ib.i_saddr = 26'h5;
        #1 chk("le_stall", ib.o_sstall, 0);
        tick(); ib.i_sstb = 0;
        chk("le_wcyc", ib.o_wcyc, 1);
        chk("le_wstb", ib.o_wstb, 1);
        chk("le_waddr", ib.o_waddr, 24'h1);
        chk("le_wsel", ib.o_wsel, 16'h00F0);
        tick();
        ib.i_wack = 1; ib.i_wdata = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        tick(); ib.i_wack = 0;
        chk("le_sack", ib.o_sack, 1);
        chk("le_sdata", ib.o_sdata, 32'h8899AABB);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wbupsz_wc.md
Name: wbupsz_wc

Overview:
Wishbone pipelined upsizer (SMALL_DW to WIDE_DW) with optional write coalescing. Successor to the plain upsizer. Sits between a narrow master (CPU/DMA) and a wide memory or crossbar port. Consecutive small writes that land in one wide word while the wide bus stalls are merged into a single wide write. Each merged write still gets its own small ack.

Parameters:
ADDRESS_WIDTH, 28, byte address width.
WIDE_DW, 512, wide data width; power of 2, at least 2*SMALL_DW.
SMALL_DW, 32, narrow data width.
LGFIFO, 5, log2 of the outstanding wide-transaction FIFO depth.
OPT_LITTLE_ENDIAN, 0, 1 = lane 0 in the LSBs; 0 = lane 0 in the MSBs.
OPT_COALESCE, 1, enable write merging.
OPT_LOWPOWER, 0, zero the data/sel/return registers when idle.

Ports:
i_clk  in  1  clock
i_reset  in  1  sync active-high reset
i_scyc, i_sstb, i_swe  in  1 each  small WB request
i_saddr  in  ADDRESS_WIDTH-log2(SMALL_DW/8)  small word address
i_sdata  in  SMALL_DW  write data
i_ssel  in  SMALL_DW/8  byte selects
o_sstall, o_sack, o_serr  out  1 each  small WB response
o_sdata  out  SMALL_DW  read data
o_wcyc, o_wstb, o_wwe  out  1 each  wide WB request
o_waddr  out  ADDRESS_WIDTH-log2(WIDE_DW/8)  wide word address
o_wdata  out  WIDE_DW  wide write data
o_wsel  out  WIDE_DW/8  wide byte selects
i_wstall, i_wack, i_werr  in  1 each  wide WB response
i_wdata  in  WIDE_DW  wide read data

Behaviour:
- Reset and interface: reset is i_reset, synchronous, active-high; clock is i_clk.
- On reset, or whenever i_scyc is low, all outputs except o_sdata are 0, the FIFO is flushed and the ack counter is cleared.
- o_sdata is 0 after reset when OPT_LOWPOWER=1, otherwise don't-care.
- Definitions: RATIO = WIDE_DW/SMALL_DW; LGR = log2(RATIO); lane = i_saddr[LGR-1:0]; wide address = the upper bits of i_saddr.
- Request register holds stb, we, addr, data, sel, first lane, count (1..RATIO) and last lane.
- Acceptance:
  - A request is accepted when i_sstb && !o_sstall. It loads the register as a new wide transaction, with data/sel shifted into the lane position.
  - o_wstb is asserted the cycle after acceptance.
  - o_wstb = r_stb && !fifo_full.
  - When o_wstb && !i_wstall, one FIFO entry {first lane, count-1} is pushed.
- Coalescing (OPT_COALESCE=1): a request merges into the register, rather than stalling, when all of the following hold:
  - r_stb, and (i_wstall or fifo_full);
  - i_swe && r_we;
  - same wide address;
  - lane == last+1;
  - count < RATIO.
- On a merge: data and sel are OR'd into the lane, last++, count++. A merge does not issue a new wide cycle.
- Stall: o_sstall = r_stb && (i_wstall || fifo_full) && !merge_ok. o_sstall is also high when i_swe differs from the direction of outstanding work (r_stb, FIFO non-empty or ack counter non-zero); that request waits until everything drains.
- Reads are never merged.
- Read return:
  - On i_wack, the FIFO pops and i_wdata is shifted by first lane.
  - o_sack is high and o_sdata valid exactly 1 cycle after i_wack.
- Write return:
  - On i_wack, ack_cnt += count.
  - o_sack = (ack_cnt != 0); ack_cnt decrements by 1 per cycle; an add and a decrement in the same cycle are both applied.
  - Counter width is log2(RATIO*2^LGFIFO)+1 bits.
- o_wcyc: set on the first accepted request. Cleared when i_scyc drops, on i_werr, or the cycle o_serr is high.
- Error:
  - i_werr while o_wcyc gives o_serr=1 for one cycle, the next cycle.
  - On the same edge: r_stb, the FIFO and ack_cnt clear, and no further o_sack is issued.
  - Requests stall until i_scyc falls.
- FIFO full: no new o_wstb; acks still drain normally.
- i_wack with an empty FIFO is a protocol violation and the result is undefined; the formal assertion flags it.

Decomposition:
- No shared package. RATIO and LGR are localparams.
- Reuse the existing sfifo (BW=2*LGR, LGFLEN=LGFIFO) as the only sub-module.
- Shift/merge and the ack counter stay inline.

Test Plan:
Config for all scenarios unless noted: WIDE_DW=128, SMALL_DW=32, big endian, LGFIFO=5.
1. Read: single read i_saddr=0x5, i_wdata=0x00112233_44556677_8899AABB_CCDDEEFF -> o_waddr=1, o_wsel=16'h0F00; o_sdata=0x44556677 with o_sack exactly 1 cycle after i_wack.
2. Coalesce: i_wstall=1, writes 0x8..0xB with data 1,2,3,4 and sel F -> none stalled; release stall gives one wide write, addr 2, sel FFFF, data {1,2,3,4}; one i_wack gives o_sack on 4 consecutive cycles.
3. Gap: i_wstall=1, write 0x8 then 0xA -> 0xA stalled; two wide writes with sel F000 then 00F0; two o_sack.
4. Direction change: write 0x8 then read 0x9 -> read stalled until the write o_sack; then read addr 2, sel 0F00.
5. Error: i_werr with 2 outstanding reads -> o_serr 1 cycle later, o_wcyc low on that edge, no o_sack; further i_sstb stalled until i_scyc=0.
6. FIFO full and reset: LGFIFO=2, little endian, no acks -> 4 reads issued, 5th stalled; i_reset mid-operation -> all outputs 0 next cycle; fresh read afterwards gives correct LSB-lane data.
